// File: rtl/fetch_unit.sv
// fetch_unit: MINI-RISC instruction fetch stage.
// Reads the PC, issues synchronous imem reads, buffers {instr, pc} in a small
// FIFO and hands them to decode over valid/ready. Handles flush and halt.
// Optional performance counters are built only when FETCH_PERF_EN is defined.
module fetch_unit #(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_addr,
  output logic               pc_inc,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               flush,
  input  logic               halt,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [ADDR_W-1:0]  dec_pc,
  output logic [15:0]        perf_fetches,
  output logic [15:0]        perf_stalls
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [INSTR_W-1:0] r_instr_mem [DEPTH];
  logic [ADDR_W-1:0]  r_pc_mem    [DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_inflight;
  logic [ADDR_W-1:0]  r_inflight_pc;
  logic               r_inflight_epoch;
  logic               r_epoch;

  logic               w_pop;
  logic               w_push;
  logic               w_issue;
  int unsigned        w_credit;
  logic [PTR_W-1:0]   w_wptr_nxt;
  logic [PTR_W-1:0]   w_rptr_nxt;

  // Handshake, credit check and response acceptance.
  always_comb begin
    dec_valid  = (r_count != '0);
    w_pop      = dec_valid & dec_ready;
    // Entries already committed (buffered + in flight) minus the one leaving now.
    w_credit   = 32'(r_count) + 32'(r_inflight) - 32'(w_pop);
    w_issue    = !rst && !flush && !halt && (w_credit < DEPTH);
    // Responses from a stale epoch or arriving during a flush are dropped.
    w_push     = r_inflight && (r_inflight_epoch == r_epoch) && !flush;
    w_wptr_nxt = (r_wptr == LAST_PTR) ? '0 : r_wptr + PTR_W'(1);
    w_rptr_nxt = (r_rptr == LAST_PTR) ? '0 : r_rptr + PTR_W'(1);
  end

  // Outputs toward PC, memory and decode; head fields read as 0 when empty.
  always_comb begin
    imem_en   = w_issue;
    pc_inc    = w_issue;
    imem_addr = pc_addr;
    dec_instr = dec_valid ? r_instr_mem[r_rptr] : '0;
    dec_pc    = dec_valid ? r_pc_mem[r_rptr]    : '0;
  end

  // FIFO pointers, occupancy and epoch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_epoch <= 1'b0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_epoch <= ~r_epoch;
    end else begin
      if (w_push) r_wptr <= w_wptr_nxt;
      if (w_pop)  r_rptr <= w_rptr_nxt;
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // In-flight read tracking; cleared by any cycle without an issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight       <= 1'b0;
      r_inflight_pc    <= '0;
      r_inflight_epoch <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc    <= pc_addr;
        r_inflight_epoch <= r_epoch;
      end
    end
  end

  // FIFO storage; no reset needed since the head is masked when empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_mem[r_wptr] <= imem_rdata;
      r_pc_mem[r_wptr]    <= r_inflight_pc;
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] r_perf_fetches;
  logic [15:0] r_perf_stalls;

  // Saturating issue and backpressure counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetches <= '0;
      r_perf_stalls  <= '0;
    end else begin
      if (w_issue && (r_perf_fetches != 16'hFFFF)) begin
        r_perf_fetches <= r_perf_fetches + 16'd1;
      end
      if (dec_valid && !dec_ready && (r_perf_stalls != 16'hFFFF)) begin
        r_perf_stalls <= r_perf_stalls + 16'd1;
      end
    end
  end

  assign perf_fetches = r_perf_fetches;
  assign perf_stalls  = r_perf_stalls;
`else
  assign perf_fetches = '0;
  assign perf_stalls  = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a PC model, a one-cycle
// instruction memory (word = address + 16'h1000) and an in-order scoreboard.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [10:0] pc_addr;
  logic        pc_inc;
  logic        imem_en;
  logic [10:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        flush;
  logic        halt;
  logic        dec_valid;
  logic        dec_ready;
  logic [15:0] dec_instr;
  logic [10:0] dec_pc;
  logic [15:0] perf_fetches;
  logic [15:0] perf_stalls;

  logic [10:0] tgt;
  logic [10:0] sbq[$];
  int          n_vec;
  int          n_fail;
  logic [31:0] exp_fetches;
  logic [31:0] exp_stalls;

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .pc_addr      (pc_addr),
    .pc_inc       (pc_inc),
    .imem_en      (imem_en),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .flush        (flush),
    .halt         (halt),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready),
    .dec_instr    (dec_instr),
    .dec_pc       (dec_pc),
    .perf_fetches (perf_fetches),
    .perf_stalls  (perf_stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program counter: redirect on flush, advance on pc_inc.
  always @(posedge clk or posedge rst) begin
    if (rst)         pc_addr <= '0;
    else if (flush)  pc_addr <= tgt;
    else if (pc_inc) pc_addr <= pc_addr + 11'd1;
  end

  // Synchronous instruction memory.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= 16'(imem_addr) + 16'h1000;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sb_check();
    logic [10:0] e;
    if (dec_valid && dec_ready && !flush && !rst) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_fail++;
        $error("FAIL sb_extra: observed pop of pc %0h expected no delivery", dec_pc);
      end else begin
        e = sbq.pop_front();
        check("sb_pc", 32'(dec_pc), 32'(e));
        check("sb_instr", 32'(dec_instr), 32'(16'(e) + 16'h1000));
      end
    end
  endtask

  // One cycle: scoreboard and per-cycle invariants, then move to next cycle.
  task automatic step();
    #1;
    sb_check();
    check("imem_addr", 32'(imem_addr), 32'(pc_addr));
    check("inc_eq_en", 32'(pc_inc), 32'(imem_en));
    @(posedge clk);
    #2;
  endtask

  task automatic load_seq(input logic [10:0] base);
    sbq.delete();
    for (int i = 0; i < 64; i++) sbq.push_back(base + 11'(i));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec = 0;
    n_fail = 0;
`ifdef FETCH_PERF_EN
    exp_fetches = 32'd10;
    exp_stalls  = 32'd3;
`else
    exp_fetches = 32'd0;
    exp_stalls  = 32'd0;
`endif
    rst = 1'b1;
    flush = 1'b0;
    halt = 1'b0;
    dec_ready = 1'b1;
    tgt = '0;
    @(posedge clk);
    @(posedge clk);
    #3;
    check("rst_en", 32'(imem_en), 32'd0);
    check("rst_inc", 32'(pc_inc), 32'd0);
    check("rst_valid", 32'(dec_valid), 32'd0);
    check("rst_instr", 32'(dec_instr), 32'd0);
    check("rst_pc", 32'(dec_pc), 32'd0);
    check("rst_perf_f", 32'(perf_fetches), 32'd0);
    check("rst_perf_s", 32'(perf_stalls), 32'd0);
    #1;

    // Free run from PC 0.
    load_seq(11'h000);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      check("fr_valid", 32'(dec_valid), 32'(c >= 2));
      check("fr_en", 32'(imem_en), 32'd1);
      step();
    end

    // Backpressure: head holds at pc 6, PC stops after DEPTH outstanding.
    dec_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      check("bp_inc", 32'(pc_inc), 32'd0);
      check("bp_pc", 32'(dec_pc), 32'h6);
      check("bp_valid", 32'(dec_valid), 32'd1);
      step();
    end
    dec_ready = 1'b1;
    for (int c = 0; c < 4; c++) step();

    // Flush to 0x040.
    flush = 1'b1;
    tgt = 11'h040;
    #1;
    check("fl_en", 32'(imem_en), 32'd0);
    step();
    flush = 1'b0;
    load_seq(11'h040);
    #1;
    check("fl_v1", 32'(dec_valid), 32'd0);
    check("fl_addr", 32'(imem_addr), 32'h40);
    check("fl_en1", 32'(imem_en), 32'd1);
    step();
    #1;
    check("fl_v2", 32'(dec_valid), 32'd0);
    step();
    #1;
    check("fl_v3", 32'(dec_valid), 32'd1);
    check("fl_pc3", 32'(dec_pc), 32'h40);
    step();
    step();

    // Halt for 4 cycles: in-flight 0x43 still delivered, no issue.
    halt = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("h_en", 32'(imem_en), 32'd0);
      check("h_valid", 32'(dec_valid), 32'(c < 2));
      if (c == 1) check("h_pc", 32'(dec_pc), 32'h43);
      step();
    end
    halt = 1'b0;
    #1;
    check("h_res_addr", 32'(imem_addr), 32'h44);
    check("h_res_en", 32'(imem_en), 32'd1);
    step();
    step();

    // Fill FIFO to 2 entries, then async reset mid-cycle.
    dec_ready = 1'b0;
    step();
    #1;
    check("pre_rst_valid", 32'(dec_valid), 32'd1);
    check("pre_rst_pc", 32'(dec_pc), 32'h44);
    rst = 1'b1;
    #1;
    check("ar_valid", 32'(dec_valid), 32'd0);
    check("ar_pc", 32'(dec_pc), 32'd0);
    check("ar_instr", 32'(dec_instr), 32'd0);
    check("ar_en", 32'(imem_en), 32'd0);
    check("ar_inc", 32'(pc_inc), 32'd0);
    load_seq(11'h000);
    dec_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // 10 fetches, then halt and 3 backpressure cycles.
    for (int c = 0; c < 10; c++) begin
      #1;
      if (c == 2) begin
        check("pr_valid", 32'(dec_valid), 32'd1);
        check("pr_pc", 32'(dec_pc), 32'd0);
      end
      step();
    end
    halt = 1'b1;
    step();
    dec_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("st_pc", 32'(dec_pc), 32'h9);
      check("st_en", 32'(imem_en), 32'd0);
      step();
    end
    dec_ready = 1'b1;
    step();
    #1;
    check("perf_fetches", 32'(perf_fetches), exp_fetches);
    check("perf_stalls", 32'(perf_stalls), exp_stalls);
    check("end_valid", 32'(dec_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
